// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
// Shared definitions for the push-button conditioning path:
//   - default channel count and the {U,D,L,R} bit positions;
//   - default debounce length (10 ms at 100 MHz) and counter width;
//   - small edge-detect helpers used by every debounce channel.
// Optional feature macro used by this slice: BTN_RELEASE_PULSE_EN.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    localparam int NUM_BTNS_DEF        = 4;
    localparam int BTN_U               = 3;
    localparam int BTN_D               = 2;
    localparam int BTN_L               = 1;
    localparam int BTN_R               = 0;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int CNT_BITS_DEF        = 20;

    // True when a debounced level goes from 0 to 1 across one edge.
    function automatic logic is_rise(input logic cur, input logic nxt);
        return (~cur) & nxt;
    endfunction

    // True when a debounced level goes from 1 to 0 across one edge.
    function automatic logic is_fall(input logic cur, input logic nxt);
        return cur & (~nxt);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the button-side signals of the conditioner.
//   btn_raw     : raw asynchronous button levels (driven by master)
//   btn_level   : debounced levels (driven by slave)
//   btn_press   : one-cycle pulse per accepted press (driven by slave)
//   any_press   : OR of btn_press, same cycle (driven by slave)
//   btn_release : one-cycle pulse per accepted release, only when
//                 BTN_RELEASE_PULSE_EN is defined
// Modports: master = pins/consumer side, slave = conditioner side.
// -----------------------------------------------------------------------------
interface button_conditioner_if
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTNS = NUM_BTNS_DEF
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic                any_press;
`ifdef BTN_RELEASE_PULSE_EN
    logic [NUM_BTNS-1:0] btn_release;

    modport master (output btn_raw, input btn_level, btn_press, any_press, btn_release);
    modport slave  (input btn_raw, output btn_level, btn_press, any_press, btn_release);
`else
    modport master (output btn_raw, input btn_level, btn_press, any_press);
    modport slave  (input btn_raw, output btn_level, btn_press, any_press);
`endif

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// button_conditioner_debounce_channel
// One button: two-flop synchroniser, stability counter, edge pulses.
// A level change is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with the current debounced level; any
// agreeing sample restarts the count.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   raw           : asynchronous raw button input
//   level         : registered debounced level
//   press         : registered one-cycle pulse on accepted 0->1
//   press_next    : combinational value press takes at the next edge
//   rel_pulse     : registered one-cycle pulse on accepted 1->0
//                   (only with BTN_RELEASE_PULSE_EN)
// -----------------------------------------------------------------------------
module button_conditioner_debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_BITS        = CNT_BITS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic press_next
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic rel_pulse
`endif
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1'b1);

    logic                s1_r;
    logic                s2_r;
    logic                level_r;
    logic                press_r;
    logic                release_r;
    logic [CNT_BITS-1:0] cnt_r;

    logic                mismatch_s;
    logic                accept_s;
    logic                level_next_s;
    logic                press_next_s;
    logic                release_next_s;
    logic [CNT_BITS-1:0] cnt_next_s;

    // Next-state for the stability counter, debounced level and edge pulses.
    always_comb begin
        mismatch_s     = s2_r ^ level_r;
        accept_s       = mismatch_s & (cnt_r == CNT_LAST);
        cnt_next_s     = {CNT_BITS{1'b0}};
        level_next_s   = level_r;
        if (accept_s) begin
            level_next_s = s2_r;
            cnt_next_s   = {CNT_BITS{1'b0}};
        end else if (mismatch_s) begin
            // Cannot wrap: reaching CNT_LAST while mismatched means accept.
            cnt_next_s   = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s   = {CNT_BITS{1'b0}};
        end
        press_next_s   = is_rise(level_r, level_next_s);
        release_next_s = is_fall(level_r, level_next_s);
    end

    // Synchroniser, counter, level and pulse registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            cnt_r     <= {CNT_BITS{1'b0}};
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            s1_r      <= raw;
            s2_r      <= s1_r;
            cnt_r     <= cnt_next_s;
            level_r   <= level_next_s;
            press_r   <= press_next_s;
            release_r <= release_next_s;
        end
    end

    assign level      = level_r;
    assign press      = press_r;
    assign press_next = press_next_s;
`ifdef BTN_RELEASE_PULSE_EN
    assign rel_pulse  = release_r;
`else
    // Release edges still move level; the pulse simply has no consumer.
    logic unused_release_s;
    assign unused_release_s = release_r;
`endif

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions NUM_BTNS raw push-buttons ({U,D,L,R} = [3:0]) for the
// collision / state-generation logic: one debounce channel per button plus a
// registered any_press that is high in the same cycle as any btn_press bit.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   bus      : button_conditioner_if.slave (btn_raw in; btn_level,
//              btn_press, any_press and optional btn_release out)
// Optional feature: BTN_RELEASE_PULSE_EN adds btn_release pulses.
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTNS        = NUM_BTNS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_BITS        = CNT_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    button_conditioner_if.slave  bus
);

    logic [NUM_BTNS-1:0] level_s;
    logic [NUM_BTNS-1:0] press_s;
    logic [NUM_BTNS-1:0] press_next_s;
`ifdef BTN_RELEASE_PULSE_EN
    logic [NUM_BTNS-1:0] release_s;
`endif
    logic                any_press_r;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        button_conditioner_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .raw        (bus.btn_raw[i]),
            .level      (level_s[i]),
            .press      (press_s[i]),
            .press_next (press_next_s[i])
`ifdef BTN_RELEASE_PULSE_EN
            ,
            .rel_pulse  (release_s[i])
`endif
        );
    end

    // Registered OR built from the channels' next press values so it lines
    // up with btn_press in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            any_press_r <= 1'b0;
        end else begin
            any_press_r <= |press_next_s;
        end
    end

    assign bus.btn_level   = level_s;
    assign bus.btn_press   = press_s;
    assign bus.any_press   = any_press_r;
`ifdef BTN_RELEASE_PULSE_EN
    assign bus.btn_release = release_s;
`endif

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions the four raw push-buttons (btnU, btnD, btnL, btnR) before they reach the collision and state-generation logic. Per button, it provides:
- two-flop synchronisation;
- counter-based debouncing;
- a one-cycle press pulse, so a held or bouncing button scores at most one hit per physical press.

It sits between the top-level button pins and the collision/stateGenerator modules in the clk domain.

Parameters:
NUM_BTNS, 4, number of button channels; bit order {U,D,L,R} = [3:0]
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 1
CNT_BITS, 20, debounce counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES-1

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset, sampled on rising clk
btn_raw  input  NUM_BTNS  asynchronous raw button levels, active-high
btn_level  output  NUM_BTNS  debounced button level
btn_press  output  NUM_BTNS  one-cycle pulse on accepted 0->1 transition
any_press  output  1  OR of btn_press, same cycle

Behaviour:
- Single clock domain. Reset is synchronous and active-low (reset_n=0 at a rising clk edge).
- Reset values:
  - sync flops 0, debounce counters 0;
  - btn_level 0, btn_press 0, any_press 0;
  - btn_release 0 (when compiled in).
- Per channel:
  - s1 <= btn_raw[i]; s2 <= s1. This is the only use of btn_raw.
- Debounce, per channel; mismatch = (s2 != btn_level[i]):
  - mismatch and cnt == DEBOUNCE_CYCLES-1: btn_level[i] <= s2, cnt <= 0.
  - mismatch otherwise: cnt <= cnt+1.
  - no mismatch: cnt <= 0. Any bounce back to the current stable level restarts the count.
- btn_press[i] <= 1 exactly on the edge where btn_level[i] flips 0->1; otherwise 0. It is never high two cycles in a row.
- Latency: if btn_raw is first captured high at edge N and stays high, btn_level and btn_press change after edge N+1+DEBOUNCE_CYCLES. Release has identical latency.
- Channels are independent:
  - simultaneous presses on several buttons give simultaneous btn_press bits;
  - any_press = |btn_press (registered alongside, same cycle).
- Held button: no further pulses until a debounced release, then a new debounced press.
- Pulse shorter than DEBOUNCE_CYCLES (post-sync): no level change, no pulse.
- Reset mid-operation: all state clears immediately. A pulse pending in flight is discarded.
  - A button held across reset release produces one btn_press after DEBOUNCE_CYCLES+2 cycles.
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 and cleared on accept.

Optional Feature:
Macro BTN_RELEASE_PULSE_EN.
- Defined: adds output btn_release [NUM_BTNS] (reset 0), a one-cycle pulse on the edge btn_level[i] flips 1->0. Same latency as press.
- Undefined: port absent; release transitions only update btn_level.

Decomposition:
- Shared definitions file (ddr_definitions.v), holding:
  - NUM_BTNS;
  - button index constants BTN_U=3, BTN_D=2, BTN_L=1, BTN_R=0;
  - DEBOUNCE_CYCLES default.
- One sub-module, debounce_channel (synchroniser + counter + edge pulse for one bit). It is instantiated NUM_BTNS times via generate; the top only does the OR for any_press.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles with btn_raw=4'b1111 → all outputs 0 throughout reset.
- Clean press: bench DEBOUNCE_CYCLES=4, reset done, btn_raw[3] high from before edge 10 and held → btn_level[3] and btn_press[3] rise after edge 15. btn_press[3] falls after edge 16. any_press mirrors btn_press[3]. No further pulse while held 100 cycles.
- Bounce rejection: btn_raw[1] toggles 1,0,1,0 every 2 cycles, then steady 1 → no output until 4 stable post-sync cycles. Then exactly one btn_press[1].
- Short glitch: btn_raw[0] high for 3 cycles only (DEBOUNCE_CYCLES=4) → btn_level[0] stays 0, no pulse.
- Simultaneous/independent: btn_raw=4'b1010 rising on the same cycle → btn_press=4'b1010 for one cycle. Later, releasing bit 3 while pressing bit 0 → bit 0 pulses, bit 1 level unchanged. With BTN_RELEASE_PULSE_EN, btn_release[3] pulses on the same edge.
- Reset mid-count: assert reset_n=0 when cnt=2 on a rising press → no pulse. After release, with the button still held, exactly one btn_press after DEBOUNCE_CYCLES+2 cycles.
